// File: rtl/branch_rs_pkg.sv
// Shared widths, opcode encoding and reset constants for the branch reservation station.
package branch_rs_pkg;

    localparam int DATA_W      = 32;
    localparam int INST_ADDR_W = 32;
    localparam int RS_DEPTH    = 4;
    localparam int TAG_W       = 3;

    typedef logic [DATA_W-1:0]      data_bus_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_BEQ  = 8'h10,
        OP_BNE  = 8'h11,
        OP_BLT  = 8'h12,
        OP_BGE  = 8'h13,
        OP_BLTU = 8'h14,
        OP_BGEU = 8'h15
    } op_bus_t;

    localparam inst_addr_bus_t ADDR_FREE = '0;

endpackage

// File: rtl/branch_rs_if.sv
// Dispatch, CDB and issue signals of the branch reservation station.
interface branch_rs_if
    import branch_rs_pkg::*;
#(
    parameter int TAG_W = 3
);
    logic           flush;
    logic           DispEn;
    op_bus_t        DispOp;
    data_bus_t      DispVO;
    data_bus_t      DispVT;
    logic [TAG_W-1:0] DispTagO;
    logic [TAG_W-1:0] DispTagT;
    data_bus_t      DispImm;
    inst_addr_bus_t DispPC;
    logic           AluCdbEn;
    logic [TAG_W-1:0] AluCdbTag;
    data_bus_t      AluCdbData;
    logic           LsCdbEn;
    logic [TAG_W-1:0] LsCdbTag;
    data_bus_t      LsCdbData;
    logic           RsFull;
    logic           BranchWorkEn;
    data_bus_t      operandO;
    data_bus_t      operandT;
    op_bus_t        opCode;
    data_bus_t      imm;
    inst_addr_bus_t PC;

    modport master (
        output flush, DispEn, DispOp, DispVO, DispVT, DispTagO, DispTagT, DispImm, DispPC,
        output AluCdbEn, AluCdbTag, AluCdbData, LsCdbEn, LsCdbTag, LsCdbData,
        input  RsFull, BranchWorkEn, operandO, operandT, opCode, imm, PC
    );

    modport slave (
        input  flush, DispEn, DispOp, DispVO, DispVT, DispTagO, DispTagT, DispImm, DispPC,
        input  AluCdbEn, AluCdbTag, AluCdbData, LsCdbEn, LsCdbTag, LsCdbData,
        output RsFull, BranchWorkEn, operandO, operandT, opCode, imm, PC
    );

endinterface

// File: rtl/branch_rs_prio_enc.sv
// Lowest-index priority encoder: request vector in, index of the lowest set bit plus valid out.
module rs_prio_enc #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[W-1:0];
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: buffers dispatched branches, wakes operands from the ALU/LS CDBs
// and issues the lowest-index ready entry as a registered request.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int RS_DEPTH = 4,
    parameter int TAG_W    = 3
) (
    input logic        clk,
    input logic        rst_n,
    branch_rs_if.slave bus
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] busy;
    logic [RS_DEPTH-1:0] ready;
    op_bus_t             op_q   [RS_DEPTH];
    data_bus_t           imm_q  [RS_DEPTH];
    inst_addr_bus_t      pc_q   [RS_DEPTH];
    data_bus_t           vo_q   [RS_DEPTH];
    data_bus_t           vt_q   [RS_DEPTH];
    logic [TAG_W-1:0]    tago_q [RS_DEPTH];
    logic [TAG_W-1:0]    tagt_q [RS_DEPTH];

    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             free_vld;
    logic             sel_vld;
    logic             disp_go;

    function automatic logic cdb_hit(input logic en, input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] tag);
        return en && (tag != '0) && (cdb_tag == tag);
    endfunction

    // Readiness is judged on registered state, so a wakeup this cycle issues next cycle.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready[i] = busy[i] && (tago_q[i] == '0) && (tagt_q[i] == '0);
        end
    end

    rs_prio_enc #(.N(RS_DEPTH), .W(IDX_W)) u_free_pick (
        .req (~busy),
        .idx (free_idx),
        .vld (free_vld)
    );

    rs_prio_enc #(.N(RS_DEPTH), .W(IDX_W)) u_ready_pick (
        .req (ready),
        .idx (sel_idx),
        .vld (sel_vld)
    );

    assign bus.RsFull = &busy;
    assign disp_go    = bus.DispEn && free_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy             <= '0;
            bus.BranchWorkEn <= 1'b0;
            bus.operandO     <= '0;
            bus.operandT     <= '0;
            bus.imm          <= '0;
            bus.opCode       <= OP_NOP;
            bus.PC           <= ADDR_FREE;
            for (int i = 0; i < RS_DEPTH; i++) begin
                op_q[i]   <= OP_NOP;
                imm_q[i]  <= '0;
                pc_q[i]   <= ADDR_FREE;
                vo_q[i]   <= '0;
                vt_q[i]   <= '0;
                tago_q[i] <= '0;
                tagt_q[i] <= '0;
            end
        end else if (bus.flush) begin
            busy             <= '0;
            bus.BranchWorkEn <= 1'b0;
        end else begin
            bus.BranchWorkEn <= sel_vld;
            if (sel_vld) begin
                bus.operandO  <= vo_q[sel_idx];
                bus.operandT  <= vt_q[sel_idx];
                bus.opCode    <= op_q[sel_idx];
                bus.imm       <= imm_q[sel_idx];
                bus.PC        <= pc_q[sel_idx];
                busy[sel_idx] <= 1'b0;
            end

            // ALU takes precedence if both buses ever carry the same tag.
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i]) begin
                    if (cdb_hit(bus.AluCdbEn, bus.AluCdbTag, tago_q[i])) begin
                        vo_q[i]   <= bus.AluCdbData;
                        tago_q[i] <= '0;
                    end else if (cdb_hit(bus.LsCdbEn, bus.LsCdbTag, tago_q[i])) begin
                        vo_q[i]   <= bus.LsCdbData;
                        tago_q[i] <= '0;
                    end
                    if (cdb_hit(bus.AluCdbEn, bus.AluCdbTag, tagt_q[i])) begin
                        vt_q[i]   <= bus.AluCdbData;
                        tagt_q[i] <= '0;
                    end else if (cdb_hit(bus.LsCdbEn, bus.LsCdbTag, tagt_q[i])) begin
                        vt_q[i]   <= bus.LsCdbData;
                        tagt_q[i] <= '0;
                    end
                end
            end

            if (disp_go) begin
                busy[free_idx]  <= 1'b1;
                op_q[free_idx]  <= bus.DispOp;
                imm_q[free_idx] <= bus.DispImm;
                pc_q[free_idx]  <= bus.DispPC;
                if (cdb_hit(bus.AluCdbEn, bus.AluCdbTag, bus.DispTagO)) begin
                    vo_q[free_idx]   <= bus.AluCdbData;
                    tago_q[free_idx] <= '0;
                end else if (cdb_hit(bus.LsCdbEn, bus.LsCdbTag, bus.DispTagO)) begin
                    vo_q[free_idx]   <= bus.LsCdbData;
                    tago_q[free_idx] <= '0;
                end else begin
                    vo_q[free_idx]   <= bus.DispVO;
                    tago_q[free_idx] <= bus.DispTagO;
                end
                if (cdb_hit(bus.AluCdbEn, bus.AluCdbTag, bus.DispTagT)) begin
                    vt_q[free_idx]   <= bus.AluCdbData;
                    tagt_q[free_idx] <= '0;
                end else if (cdb_hit(bus.LsCdbEn, bus.LsCdbTag, bus.DispTagT)) begin
                    vt_q[free_idx]   <= bus.LsCdbData;
                    tagt_q[free_idx] <= '0;
                end else begin
                    vt_q[free_idx]   <= bus.DispVT;
                    tagt_q[free_idx] <= bus.DispTagT;
                end
            end
        end
    end

endmodule
